// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared 32-bit bitwise gate bank.
// Holds registered operands for SETTLE_CYCLES cycles, then returns the selected result.
module logic_unit_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] gate_a,
  output logic [31:0] gate_b,
  input  logic [31:0] gate_and,
  input  logic [31:0] gate_nand,
  input  logic [31:0] gate_or,
  input  logic [31:0] gate_nor,
  input  logic [31:0] gate_xor,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] gate_a_q, gate_a_d;
  logic [31:0] gate_b_q, gate_b_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        grant0, grant1;
  logic [2:0]  sel_op;
  logic [31:0] bank_out;

  // The pointer only breaks ties; a lone valid requester always wins.
  assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1 = req1_valid & (~req0_valid | ptr_q);
  assign sel_op = grant1 ? req1_op : req0_op;

  always_comb begin
    bank_out = 32'h0;
    unique case (op_q)
      3'd0:    bank_out = gate_and;
      3'd1:    bank_out = gate_nand;
      3'd2:    bank_out = gate_or;
      3'd3:    bank_out = gate_nor;
      3'd4:    bank_out = gate_xor;
      default: bank_out = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ready is masked while reset is asserted so no handshake is ever seen then.
        req0_ready = reset_n & grant0;
        req1_ready = reset_n & grant1;
        if (grant0 | grant1) begin
          owner_d  = grant1;
          op_d     = sel_op;
          gate_a_d = grant1 ? req1_a : req0_a;
          gate_b_d = grant1 ? req1_b : req0_b;
          if (sel_op > 3'd4) begin
            state_d     = StResp;
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
          end else begin
            state_d = StSettle;
            cnt_d   = CntInit;
          end
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          resp_data_d = bank_out;
          resp_err_d  = 1'b0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          state_d = StIdle;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      op_q        <= 3'd0;
      gate_a_q    <= 32'h0;
      gate_b_q    <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign resp0_valid = (state_q == StResp) & ~owner_q;
  assign resp1_valid = (state_q == StResp) & owner_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign gate_a      = gate_a_q;
  assign gate_b      = gate_b_q;
  assign busy        = (state_q != StIdle);

endmodule
